// File: rtl/gyro_sample_sequencer.sv
// rtl/gyro_sample_sequencer.sv - periodic six-byte gyro register reader driving an I2C master
// Optional per-transaction watchdog enabled by defining GYRO_SEQ_TIMEOUT_EN.
module gyro_sample_sequencer #(
    parameter int         CLK_FREQ       = 100_000_000,
    parameter int         SAMPLE_RATE    = 100,
    parameter logic [6:0] DEV_ADDR       = 7'h69,
    parameter logic [7:0] FIRST_REG      = 8'h28,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        i2c_start,
    output logic [6:0]  i2c_device_addr,
    output logic [7:0]  i2c_write_data,
    output logic        i2c_read_req,
    input  logic        i2c_done,
    input  logic [7:0]  i2c_read_data,
    input  logic        i2c_ack,
    output logic [15:0] gyro_x,
    output logic [15:0] gyro_y,
    output logic [15:0] gyro_z,
    output logic        sample_valid,
    output logic        busy,
    output logic        nack_err,
    output logic        overrun,
    output logic        timeout_err
);

    localparam int PERIOD = CLK_FREQ / SAMPLE_RATE;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(PERIOD - 1);

    generate
        if (PERIOD < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
            $error("gyro_sample_sequencer: PERIOD must be >= 2 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_PTR_START,
        S_PTR_WAIT,
        S_RD_START,
        S_RD_WAIT,
        S_NEXT,
        S_PUBLISH
    } state_t;

    state_t           state;
    logic [2:0]       idx;
    logic [5:0][7:0]  byte_buf;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    assign i2c_device_addr = DEV_ADDR;
    assign busy            = (state != S_IDLE);
    assign tick            = enable && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (!enable || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

`ifdef GYRO_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog;
    logic            wdog_hit;
    assign wdog_hit = (wdog == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            idx            <= '0;
            byte_buf       <= '0;
            i2c_start      <= 1'b0;
            i2c_write_data <= '0;
            i2c_read_req   <= 1'b0;
            gyro_x         <= '0;
            gyro_y         <= '0;
            gyro_z         <= '0;
            sample_valid   <= 1'b0;
            nack_err       <= 1'b0;
            overrun        <= 1'b0;
`ifdef GYRO_SEQ_TIMEOUT_EN
            wdog           <= '0;
            timeout_err    <= 1'b0;
`endif
        end else begin
            i2c_start    <= 1'b0;
            sample_valid <= 1'b0;
            nack_err     <= 1'b0;
            overrun      <= (tick && state != S_IDLE);
`ifdef GYRO_SEQ_TIMEOUT_EN
            timeout_err  <= 1'b0;
            if (state == S_PTR_WAIT || state == S_RD_WAIT) begin
                wdog <= wdog + 1'b1;
            end
`endif
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        idx   <= '0;
                        state <= S_PTR_START;
                    end
                end
                S_PTR_START: begin
                    i2c_write_data <= FIRST_REG + {5'd0, idx};
                    i2c_read_req   <= 1'b0;
                    i2c_start      <= 1'b1;
`ifdef GYRO_SEQ_TIMEOUT_EN
                    wdog           <= '0;
`endif
                    state          <= S_PTR_WAIT;
                end
                S_PTR_WAIT: begin
                    if (i2c_done) begin
                        if (i2c_ack) begin
                            state <= S_RD_START;
                        end else begin
                            nack_err <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
`ifdef GYRO_SEQ_TIMEOUT_EN
                    else if (wdog_hit) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end
`endif
                end
                S_RD_START: begin
                    i2c_read_req <= 1'b1;
                    i2c_start    <= 1'b1;
`ifdef GYRO_SEQ_TIMEOUT_EN
                    wdog         <= '0;
`endif
                    state        <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (i2c_done) begin
                        if (i2c_ack) begin
                            byte_buf[idx] <= i2c_read_data;
                            state         <= S_NEXT;
                        end else begin
                            nack_err <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
`ifdef GYRO_SEQ_TIMEOUT_EN
                    else if (wdog_hit) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end
`endif
                end
                S_NEXT: begin
                    // Samples and strobe are loaded on entry so they are visible during PUBLISH.
                    if (idx == 3'd5) begin
                        gyro_x       <= {byte_buf[1], byte_buf[0]};
                        gyro_y       <= {byte_buf[3], byte_buf[2]};
                        gyro_z       <= {byte_buf[5], byte_buf[4]};
                        sample_valid <= 1'b1;
                        state        <= S_PUBLISH;
                    end else begin
                        idx   <= idx + 3'd1;
                        state <= S_PTR_START;
                    end
                end
                S_PUBLISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gyro_sample_sequencer.sv
// tb/tb_gyro_sample_sequencer.sv - scoreboard bench for gyro_sample_sequencer with I2C master model
module tb_gyro_sample_sequencer;

    localparam int PERIOD = 50;
    localparam int LAT    = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        i2c_done = 1'b0;
    logic [7:0]  i2c_read_data = 8'h00;
    logic        i2c_ack = 1'b0;
    logic        i2c_start;
    logic [6:0]  i2c_device_addr;
    logic [7:0]  i2c_write_data;
    logic        i2c_read_req;
    logic [15:0] gyro_x, gyro_y, gyro_z;
    logic        sample_valid, busy, nack_err, overrun, timeout_err;

    always #5 clk = ~clk;

    gyro_sample_sequencer #(
        .CLK_FREQ(5000), .SAMPLE_RATE(100), .DEV_ADDR(7'h69),
        .FIRST_REG(8'h28), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .i2c_start(i2c_start), .i2c_device_addr(i2c_device_addr),
        .i2c_write_data(i2c_write_data), .i2c_read_req(i2c_read_req),
        .i2c_done(i2c_done), .i2c_read_data(i2c_read_data), .i2c_ack(i2c_ack),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .sample_valid(sample_valid), .busy(busy), .nack_err(nack_err),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    int n_start = 0, n_nack = 0, n_ovr = 0, n_tmo = 0, n_valid = 0;
    bit nack_en = 0, suppress_done = 0, rd2_seen = 0;
    logic [7:0]  regs [6];
    logic [7:0]  ptr_log [$];
    logic [47:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic bit sig(input int which);
        case (which)
            0: return i2c_start;
            1: return sample_valid;
            2: return nack_err;
            3: return timeout_err;
            default: return rd2_seen;
        endcase
    endfunction

    task automatic wait_sig(input string name, input int which, input int max, output int w);
        w = 0;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk); #1;
            if (sig(which)) begin
                w = i;
                return;
            end
        end
        n_total++;
        $display("FAIL %s: no event within %0d cycles", name, max);
    endtask

    // I2C master model: done LAT cycles after start, data looked up by register pointer.
    initial begin
        logic [7:0] cur_ptr;
        logic [2:0] k;
        bit rd, aborted;
        cur_ptr = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (rst_n && i2c_start) begin
                rd = i2c_read_req;
                if (!rd) begin
                    cur_ptr = i2c_write_data;
                    ptr_log.push_back(cur_ptr);
                end else if (cur_ptr == 8'h2A) begin
                    rd2_seen = 1;
                end
                aborted = 0;
                for (int i = 0; i < LAT; i++) begin
                    @(posedge clk);
                    if (!rst_n) aborted = 1;
                end
                #1;
                if (!aborted && !suppress_done && rst_n) begin
                    k = 3'(cur_ptr - 8'h28);
                    i2c_done      = 1'b1;
                    i2c_ack       = rd ? !(nack_en && cur_ptr == 8'h2B) : 1'b1;
                    i2c_read_data = rd ? regs[k] : 8'hEE;
                    last_done_cyc = cyc;
                    @(posedge clk); #1;
                    i2c_done      = 1'b0;
                    i2c_ack       = 1'b0;
                    i2c_read_data = 8'h00;
                end
            end
        end
    end

    // Monitor: pulse counters plus scoreboard pop on every sample_valid.
    always @(negedge clk) begin
        logic [47:0] e;
        if (rst_n) begin
            if (i2c_start)   n_start++;
            if (nack_err)    n_nack++;
            if (overrun)     n_ovr++;
            if (timeout_err) n_tmo++;
            if (sample_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_valid: got sample_valid=1 expected 0");
                end else begin
                    e = exp_q.pop_front();
                    chk("gyro_x", {16'h0, gyro_x}, {16'h0, e[47:32]});
                    chk("gyro_y", {16'h0, gyro_y}, {16'h0, e[31:16]});
                    chk("gyro_z", {16'h0, gyro_z}, {16'h0, e[15:0]});
                    chk("valid_latency", cyc - last_done_cyc, 2);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int w;
        regs = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00, 8'h80};
        repeat (3) @(posedge clk); #1;
        chk("rst_start", i2c_start, 0);
        chk("rst_gyro_x", gyro_x, 0);
        chk("rst_gyro_y", gyro_y, 0);
        chk("rst_gyro_z", gyro_z, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_nack", nack_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_wdata", i2c_write_data, 0);
        chk("rst_rdreq", i2c_read_req, 0);
        chk("dev_addr", i2c_device_addr, 7'h69);
        rst_n = 1'b1;

        // Enable gating, then good frame with overruns (PERIOD shorter than the frame)
        repeat (3 * PERIOD) @(posedge clk); #1;
        chk("gated_starts", n_start, 0);
        exp_q.push_back({16'h1234, 16'hABCD, 16'h8000});
        n_ovr = 0;
        ptr_log.delete();
        enable = 1'b1;
        wait_sig("first_start", 0, 200, w);
        chk("first_start_delay", w, PERIOD + 1);
        chk("first_ptr", i2c_write_data, 8'h28);
        chk("first_rdreq", i2c_read_req, 0);
        chk("busy_in_frame", busy, 1);
        wait_sig("frame1_valid", 1, 2000, w);
        enable = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("frame1_starts", n_start, 12);
        chk("frame1_overruns", n_ovr, 5);
        chk("ptr_count", ptr_log.size(), 6);
        for (int i = 0; i < 6 && i < ptr_log.size(); i++)
            chk($sformatf("ptr%0d", i), ptr_log[i], 8'h28 + i);
        chk("idle_after_frame", busy, 0);

        // NACK on read of byte 3 aborts without publishing
        nack_en = 1;
        n_start = 0;
        ptr_log.delete();
        enable = 1'b1;
        wait_sig("nack_pulse", 2, 2000, w);
        enable = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("nack_starts", n_start, 8);
        chk("nack_count", n_nack, 1);
        chk("nack_idle", busy, 0);
        chk("nack_keep_x", gyro_x, 16'h1234);
        chk("nack_keep_y", gyro_y, 16'hABCD);
        chk("nack_keep_z", gyro_z, 16'h8000);

        // Recovery frame restarts at 0x28; enable dropped mid-frame must not abort it
        nack_en = 0;
        regs = '{8'h01, 8'h00, 8'hFF, 8'hFF, 8'h7F, 8'h7F};
        exp_q.push_back({16'h0001, 16'hFFFF, 16'h7F7F});
        enable = 1'b1;
        wait_sig("frame2_start", 0, 200, w);
        enable = 1'b0;
        chk("frame2_ptr", i2c_write_data, 8'h28);
        wait_sig("frame2_valid", 1, 2000, w);
        repeat (3) @(posedge clk); #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        // Reset during RD_WAIT of byte 2
        rd2_seen = 0;
        enable = 1'b1;
        wait_sig("rd2_wait", 4, 2000, w);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_start", i2c_start, 0);
        chk("mrst_gyro_x", gyro_x, 0);
        chk("mrst_rdreq", i2c_read_req, 0);
        chk("mrst_wdata", i2c_write_data, 0);
        repeat (3) @(posedge clk); #1;
        n_start = 0;
        exp_q.push_back({16'h0001, 16'hFFFF, 16'h7F7F});
        rst_n = 1'b1;
        wait_sig("post_reset_start", 0, 200, w);
        chk("post_reset_delay", w, PERIOD + 1);
        enable = 1'b0;
        wait_sig("frame3_valid", 1, 2000, w);
        repeat (3) @(posedge clk); #1;
        chk("frame3_starts", n_start, 12);

`ifdef GYRO_SEQ_TIMEOUT_EN
        suppress_done = 1;
        n_valid = 0;
        enable = 1'b1;
        wait_sig("tmo_start", 0, 200, w);
        enable = 1'b0;
        wait_sig("tmo_pulse", 3, 300, w);
        chk("tmo_delay", w, 100);
        repeat (2) @(posedge clk); #1;
        chk("tmo_idle", busy, 0);
        chk("tmo_no_valid", n_valid, 0);
        chk("tmo_count", n_tmo, 1);
        suppress_done = 0;
`else
        chk("no_timeout_pulses", n_tmo, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
